// File: rtl/keypad_input_ctrl_pkg.sv
// Shared definitions for the keypad decimal-entry controller: state encoding,
// digit limits and a digit-validity helper.
package keypad_input_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam logic [3:0] MAX_DIGIT = 4'd9;
    localparam int         DEC_BASE  = 10;

    function automatic logic digit_ok(input logic [3:0] d);
        return (d <= MAX_DIGIT);
    endfunction

endpackage

// File: rtl/keypad_input_ctrl_if.sv
// Bundle of request, key-event, echo and result-handshake signals between the
// CPU/decoder side (master) and the keypad entry controller (slave).
interface keypad_input_ctrl_if #(
    parameter int WIDTH = 16
) ();

    logic             req;
    logic             cancel;
    logic             key_evt;
    logic [3:0]       key_num;
    logic             busy;
    logic [2:0]       cnt;
    logic [WIDTH-1:0] partial;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ack;

    modport master (
        output req, cancel, key_evt, key_num, out_ack,
        input  busy, cnt, partial, out_valid, out_data
    );

    modport slave (
        input  req, cancel, key_evt, key_num, out_ack,
        output busy, cnt, partial, out_valid, out_data
    );

endinterface

// File: rtl/keypad_input_ctrl_dec_accum.sv
// Combinational decimal shift-in: acc_out = sat(acc_in * 10 + digit) at WIDTH bits.
module keypad_input_ctrl_dec_accum
    import keypad_input_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] acc_out
);

    // Four guard bits cover the worst case (2**WIDTH-1)*10+9 without overflow.
    logic [WIDTH+3:0] wide_sum;
    logic [WIDTH+3:0] sat_limit;

    always_comb begin
        sat_limit = {4'b0000, {WIDTH{1'b1}}};
        wide_sum  = ({4'b0000, acc_in} * (WIDTH+4)'(DEC_BASE)) + {{WIDTH{1'b0}}, digit};
        if (wide_sum > sat_limit) begin
            acc_out = {WIDTH{1'b1}};
        end else begin
            acc_out = wide_sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/keypad_input_ctrl.sv
// Collects DIGITS decimal key presses per CPU request, accumulates them into a
// saturating WIDTH-bit value and hands the result over on a valid/ack handshake.
module keypad_input_ctrl
    import keypad_input_ctrl_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    keypad_input_ctrl_if.slave  bus
);

    localparam logic [2:0] DIGITS_CNT = 3'(DIGITS);

    state_e           state_q,     state_d;
    logic             key_evt_q,   key_evt_d;
    logic [2:0]       cnt_q,       cnt_d;
    logic [WIDTH-1:0] partial_q,   partial_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;

    logic             evt;
    logic [2:0]       cnt_inc;
    logic [WIDTH-1:0] accum_next;

    assign evt     = bus.key_evt & ~key_evt_q;
    assign cnt_inc = cnt_q + 3'd1;

    keypad_input_ctrl_dec_accum #(
        .WIDTH (WIDTH)
    ) u_dec_accum (
        .acc_in  (partial_q),
        .digit   (bus.key_num),
        .acc_out (accum_next)
    );

    always_comb begin
        state_d     = state_q;
        key_evt_d   = bus.key_evt;
        cnt_d       = cnt_q;
        partial_d   = partial_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    state_d   = ST_COLLECT;
                    cnt_d     = 3'd0;
                    partial_d = '0;
                end
            end
            ST_COLLECT: begin
                if (evt && digit_ok(bus.key_num)) begin
                    partial_d = accum_next;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == DIGITS_CNT) begin
                        state_d     = ST_DONE;
                        out_data_d  = accum_next;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // partial is left alone so the echo keeps showing the result.
                if (bus.out_ack) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    cnt_d       = 3'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.cancel) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            cnt_d       = 3'd0;
            partial_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            key_evt_q   <= 1'b0;
            cnt_q       <= 3'd0;
            partial_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_evt_q   <= key_evt_d;
            cnt_q       <= cnt_d;
            partial_q   <= partial_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.cnt       = cnt_q;
    assign bus.partial   = partial_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_keypad_input_ctrl.sv
// Directed self-checking bench for keypad_input_ctrl: a 4-digit/16-bit instance
// and a 3-digit/8-bit instance for saturation, with a result scoreboard.
module tb_keypad_input_ctrl;

    logic clk;
    logic rst;

    keypad_input_ctrl_if #(.WIDTH(16)) a ();
    keypad_input_ctrl_if #(.WIDTH(8))  b ();

    keypad_input_ctrl #(.DIGITS(4), .WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    keypad_input_ctrl #(.DIGITS(3), .WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clean key edge: raise key_evt for a cycle, then release it for a cycle.
    task automatic applyStimulus(input bit sel, input logic [3:0] d);
        if (sel) begin b.key_num = d; b.key_evt = 1'b1; end
        else     begin a.key_num = d; a.key_evt = 1'b1; end
        tick(1);
        if (sel) b.key_evt = 1'b0; else a.key_evt = 1'b0;
        tick(1);
    endtask

    // Waits up to 'bound' sample points for out_valid, then pops the scoreboard.
    task automatic waitResult(input bit sel, input string tag, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            if ((sel ? b.out_valid : a.out_valid) === 1'b1) seen = 1'b1;
            else tick(1);
        end
        if (!seen) begin
            checkOutput({tag, "_valid"}, 32'(sel ? b.out_valid : a.out_valid), 32'd1);
        end else if (exp_q.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
        end else begin
            checkOutput({tag, "_data"}, sel ? 32'(b.out_data) : 32'(a.out_data), exp_q.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1;
        a.req = 0; a.cancel = 0; a.key_evt = 0; a.key_num = 0; a.out_ack = 0;
        b.req = 0; b.cancel = 0; b.key_evt = 0; b.key_num = 0; b.out_ack = 0;
        tick(2);

        checkOutput("rst_busy",      32'(a.busy),      0);
        checkOutput("rst_cnt",       32'(a.cnt),       0);
        checkOutput("rst_partial",   32'(a.partial),   0);
        checkOutput("rst_out_valid", 32'(a.out_valid), 0);
        checkOutput("rst_out_data",  32'(a.out_data),  0);
        checkOutput("rst_b_valid",   32'(b.out_valid), 0);
        rst = 1'b0;
        $display("[TB] basic entry 1,2,3,4");

        a.req = 1; tick(1); a.req = 0;
        checkOutput("t1_busy", 32'(a.busy), 1);
        applyStimulus(0, 4'd1);
        checkOutput("t1_cnt1", 32'(a.cnt), 1);
        applyStimulus(0, 4'd2);
        applyStimulus(0, 4'd3);
        checkOutput("t1_cnt3",     32'(a.cnt),     3);
        checkOutput("t1_partial3", 32'(a.partial), 123);
        checkOutput("t1_novalid",  32'(a.out_valid), 0);
        exp_q.push_back(32'd1234);
        a.key_num = 4'd4; a.key_evt = 1; tick(1);
        waitResult(0, "t1_latency", 1);
        a.key_evt = 0; tick(1);
        checkOutput("t1_done_busy", 32'(a.busy), 1);
        a.out_ack = 1; tick(1); a.out_ack = 0;
        checkOutput("t1_ack_valid",   32'(a.out_valid), 0);
        checkOutput("t1_ack_busy",    32'(a.busy),      0);
        checkOutput("t1_ack_cnt",     32'(a.cnt),       0);
        checkOutput("t1_ack_partial", 32'(a.partial),   1234);

        $display("[TB] key_evt held high for 50 cycles");
        a.req = 1; tick(1); a.req = 0;
        checkOutput("t2_partial_cleared", 32'(a.partial), 0);
        a.key_num = 4'd7; a.key_evt = 1; tick(50);
        checkOutput("t2_cnt",     32'(a.cnt),     1);
        checkOutput("t2_partial", 32'(a.partial), 7);
        a.key_evt = 0; tick(1);
        a.cancel = 1; tick(1); a.cancel = 0;
        checkOutput("t2_cancel_busy", 32'(a.busy), 0);

        $display("[TB] cancel after two digits");
        a.req = 1; tick(1); a.req = 0;
        applyStimulus(0, 4'd1);
        applyStimulus(0, 4'd2);
        checkOutput("t3_partial12", 32'(a.partial), 12);
        a.cancel = 1; tick(1); a.cancel = 0;
        checkOutput("t3_busy",    32'(a.busy),      0);
        checkOutput("t3_cnt",     32'(a.cnt),       0);
        checkOutput("t3_partial", 32'(a.partial),   0);
        checkOutput("t3_valid",   32'(a.out_valid), 0);
        applyStimulus(0, 4'd5);
        checkOutput("t3_idle_evt_cnt", 32'(a.cnt), 0);

        $display("[TB] delayed ack with presses while result pending");
        a.req = 1; tick(1); a.req = 0;
        applyStimulus(0, 4'd1);
        applyStimulus(0, 4'd2);
        applyStimulus(0, 4'd3);
        exp_q.push_back(32'd1234);
        a.key_num = 4'd4; a.key_evt = 1; tick(1);
        waitResult(0, "t4_latency", 1);
        a.key_evt = 0; tick(1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 4'd5);
        checkOutput("t4_hold_valid",   32'(a.out_valid), 1);
        checkOutput("t4_hold_data",    32'(a.out_data),  1234);
        checkOutput("t4_hold_cnt",     32'(a.cnt),       4);
        checkOutput("t4_hold_partial", 32'(a.partial),   1234);
        a.out_ack = 1; a.req = 1; tick(1); a.out_ack = 0;
        checkOutput("t4_ack_valid", 32'(a.out_valid), 0);
        checkOutput("t4_idle_gap",  32'(a.busy),      0);
        tick(1); a.req = 0;
        checkOutput("t4_restart_busy", 32'(a.busy), 1);

        $display("[TB] reset mid-entry, leading zeros, invalid key");
        applyStimulus(0, 4'd3);
        checkOutput("t5_pre_cnt", 32'(a.cnt), 1);
        rst = 1; tick(1); rst = 0;
        checkOutput("t5_rst_busy",    32'(a.busy),    0);
        checkOutput("t5_rst_cnt",     32'(a.cnt),     0);
        checkOutput("t5_rst_partial", 32'(a.partial), 0);
        a.req = 1; a.key_num = 4'd9; a.key_evt = 1; tick(1);
        a.req = 0; a.key_evt = 0;
        checkOutput("t5_req_evt_cnt",     32'(a.cnt),     0);
        checkOutput("t5_req_evt_partial", 32'(a.partial), 0);
        tick(1);
        applyStimulus(0, 4'd0);
        applyStimulus(0, 4'd0);
        applyStimulus(0, 4'd0);
        applyStimulus(0, 4'hA);
        checkOutput("t5_invalid_cnt", 32'(a.cnt), 3);
        exp_q.push_back(32'd5);
        a.key_num = 4'd5; a.key_evt = 1; tick(1);
        waitResult(0, "t5_result", 1);
        a.key_evt = 0; a.out_ack = 1; tick(1); a.out_ack = 0;

        $display("[TB] saturation on 3-digit 8-bit instance");
        b.req = 1; tick(1); b.req = 0;
        applyStimulus(1, 4'd9);
        applyStimulus(1, 4'd9);
        checkOutput("t6_partial99", 32'(b.partial), 99);
        exp_q.push_back(32'd255);
        b.key_num = 4'd9; b.key_evt = 1; tick(1);
        waitResult(1, "t6_saturate", 1);
        b.key_evt = 0;
        checkOutput("t6_partial_sat", 32'(b.partial), 255);
        b.out_ack = 1; tick(1); b.out_ack = 0;
        checkOutput("t6_ack_valid", 32'(b.out_valid), 0);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
